// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the memory channel arbiter.
package mem_arb_pkg;

  typedef enum logic {
    CH_IDLE    = 1'b0,
    CH_GRANTED = 1'b1
  } chan_state_t;

  // Index width for n items, never narrower than one bit.
  function automatic int unsigned id_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotate-priority find-first: first set bit of eligible at or after start, wrapping.
module rr_pick #(
  parameter int unsigned N   = 4,
  parameter int unsigned IDW = 2
) (
  input  logic [N-1:0]   eligible,
  input  logic [IDW-1:0] start,
  output logic           found,
  output logic [IDW-1:0] id
);

  int unsigned idx;

  // Scan N positions from start; the first hit wins.
  always_comb begin
    found = 1'b0;
    id    = '0;
    idx   = 0;
    for (int unsigned i = 0; i < N; i++) begin
      idx = (32'(start) + i) % N;
      if (!found && eligible[idx]) begin
        found = 1'b1;
        id    = IDW'(idx);
      end
    end
  end

endmodule

// File: rtl/mem_channel_arbiter.sv
// Round-robin arbiter assigning consumers to memory channels, with a per-channel
// grant-hold watchdog. The channel-finished input is named chan_release because
// "release" is a reserved word in SystemVerilog.
module mem_channel_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned NUM_CONSUMERS  = 4,
  parameter int unsigned NUM_CHANNELS   = 1,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  localparam int unsigned IDW           = id_width(NUM_CONSUMERS)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_CONSUMERS-1:0]       req,
  input  logic [NUM_CONSUMERS-1:0]       req_write,
  input  logic [NUM_CHANNELS-1:0]        chan_release,
  output logic [NUM_CHANNELS-1:0]        grant_valid,
  output logic [NUM_CHANNELS*IDW-1:0]    grant_id,
  output logic [NUM_CHANNELS-1:0]        grant_write,
  output logic [NUM_CONSUMERS-1:0]       busy_mask,
  output logic [NUM_CHANNELS-1:0]        timeout
);

  localparam int unsigned CNTW = id_width(TIMEOUT_CYCLES + 1);
  localparam logic [CNTW-1:0] CNT_LAST = (TIMEOUT_CYCLES == 0) ? '0 : CNTW'(TIMEOUT_CYCLES - 1);

  chan_state_t                state_q [NUM_CHANNELS];
  chan_state_t                state_d [NUM_CHANNELS];
  logic [IDW-1:0]             id_q    [NUM_CHANNELS];
  logic [IDW-1:0]             id_d    [NUM_CHANNELS];
  logic [CNTW-1:0]            cnt_q   [NUM_CHANNELS];
  logic [CNTW-1:0]            cnt_d   [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0]    wr_q, wr_d, to_q, to_d;
  logic [NUM_CONSUMERS-1:0]   busy_q, busy_d;
  logic [IDW-1:0]             rr_ptr_q, rr_ptr_d;

  logic [NUM_CHANNELS-1:0]           take;
  logic [NUM_CHANNELS-1:0][IDW-1:0]  pick_id;

  // Arbitration chain: each idle channel picks, then masks its pick and advances the pointer.
  for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_ch
    logic [NUM_CONSUMERS-1:0] elig_in, elig_out;
    logic [IDW-1:0]           ptr_in, ptr_out, id;
    logic                     found, grab;

    if (c == 0) begin : g_first
      assign elig_in = req & ~busy_q;
      assign ptr_in  = rr_ptr_q;
    end else begin : g_next
      assign elig_in = g_ch[c-1].elig_out;
      assign ptr_in  = g_ch[c-1].ptr_out;
    end

    rr_pick #(
      .N   (NUM_CONSUMERS),
      .IDW (IDW)
    ) u_pick (
      .eligible (elig_in),
      .start    (ptr_in),
      .found    (found),
      .id       (id)
    );

    assign grab     = (state_q[c] == CH_IDLE) && found;
    assign elig_out = grab ? (elig_in & ~(NUM_CONSUMERS'(1) << id)) : elig_in;
    assign ptr_out  = !grab ? ptr_in :
                      (id == IDW'(NUM_CONSUMERS - 1)) ? '0 : id + IDW'(1);
    assign take[c]    = grab;
    assign pick_id[c] = id;
  end

  // Pointer follows the last grant of the cycle, unchanged when nothing was granted.
  assign rr_ptr_d = g_ch[NUM_CHANNELS-1].ptr_out;

  // Per-channel next state: grant latching, release, watchdog expiry.
  always_comb begin
    busy_d = busy_q;
    wr_d   = wr_q;
    to_d   = '0;
    for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
      state_d[c] = state_q[c];
      id_d[c]    = id_q[c];
      cnt_d[c]   = cnt_q[c];
      case (state_q[c])
        CH_IDLE: begin
          if (take[c]) begin
            state_d[c]         = CH_GRANTED;
            id_d[c]            = pick_id[c];
            wr_d[c]            = req_write[pick_id[c]];
            cnt_d[c]           = '0;
            busy_d[pick_id[c]] = 1'b1;
          end
        end
        CH_GRANTED: begin
          if (chan_release[c]) begin
            state_d[c]      = CH_IDLE;
            busy_d[id_q[c]] = 1'b0;
          end else if (TIMEOUT_CYCLES != 0 && cnt_q[c] == CNT_LAST) begin
            state_d[c]      = CH_IDLE;
            busy_d[id_q[c]] = 1'b0;
            to_d[c]         = 1'b1;
          end else if (cnt_q[c] != '1) begin
            cnt_d[c] = cnt_q[c] + CNTW'(1);
          end
        end
        default: state_d[c] = CH_IDLE;
      endcase
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
        state_q[c] <= CH_IDLE;
        id_q[c]    <= '0;
        cnt_q[c]   <= '0;
      end
      wr_q     <= '0;
      to_q     <= '0;
      busy_q   <= '0;
      rr_ptr_q <= '0;
    end else begin
      for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
        state_q[c] <= state_d[c];
        id_q[c]    <= id_d[c];
        cnt_q[c]   <= cnt_d[c];
      end
      wr_q     <= wr_d;
      to_q     <= to_d;
      busy_q   <= busy_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  // Outputs come straight from registers.
  always_comb begin
    grant_valid = '0;
    grant_id    = '0;
    for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
      grant_valid[c]           = (state_q[c] == CH_GRANTED);
      grant_id[c*IDW +: IDW]   = id_q[c];
    end
  end

  assign grant_write = wr_q;
  assign busy_mask   = busy_q;
  assign timeout     = to_q;

endmodule

// File: tb/tb_mem_channel_arbiter.sv
// Directed bench for mem_channel_arbiter: a one-channel and a two-channel instance,
// expectations queued when stimulus is driven and checked after the next edge.
module tb_mem_channel_arbiter;

  logic clk = 1'b0;
  logic reset;

  logic [3:0] req_a, rw_a;
  logic [0:0] rel_a, gv_a, gw_a, to_a;
  logic [1:0] gid_a;
  logic [3:0] busy_a;

  logic [3:0] req_b, rw_b;
  logic [1:0] rel_b, gv_b, gw_b, to_b;
  logic [3:0] gid_b;
  logic [3:0] busy_b;

  always #5 clk = ~clk;

  mem_channel_arbiter #(
    .NUM_CONSUMERS  (4),
    .NUM_CHANNELS   (1),
    .TIMEOUT_CYCLES (8)
  ) u_dut_a (
    .clk          (clk),
    .reset        (reset),
    .req          (req_a),
    .req_write    (rw_a),
    .chan_release (rel_a),
    .grant_valid  (gv_a),
    .grant_id     (gid_a),
    .grant_write  (gw_a),
    .busy_mask    (busy_a),
    .timeout      (to_a)
  );

  mem_channel_arbiter #(
    .NUM_CONSUMERS  (4),
    .NUM_CHANNELS   (2),
    .TIMEOUT_CYCLES (8)
  ) u_dut_b (
    .clk          (clk),
    .reset        (reset),
    .req          (req_b),
    .req_write    (rw_b),
    .chan_release (rel_b),
    .grant_valid  (gv_b),
    .grant_id     (gid_b),
    .grant_write  (gw_b),
    .busy_mask    (busy_b),
    .timeout      (to_b)
  );

  typedef struct {
    string      tag;
    bit         sel;
    logic [13:0] exp;
  } item_t;

  item_t sb[$];
  int n_cmp = 0;
  int n_err = 0;

  // Record layout: {valid[1:0], id[3:0], write[1:0], busy[3:0], timeout[1:0]}.
  function automatic logic [13:0] mk(input logic [1:0] gv, input logic [3:0] id,
                                     input logic [1:0] gw, input logic [3:0] busy,
                                     input logic [1:0] to);
    return {gv, id, gw, busy, to};
  endfunction

  // id and write are don't-care on a channel without a grant, so they read as zero here.
  function automatic logic [13:0] obs_a();
    return mk({1'b0, gv_a}, {2'b00, gv_a[0] ? gid_a : 2'b00},
              {1'b0, gv_a[0] & gw_a[0]}, busy_a, {1'b0, to_a});
  endfunction

  function automatic logic [13:0] obs_b();
    return mk(gv_b, {gv_b[1] ? gid_b[3:2] : 2'b00, gv_b[0] ? gid_b[1:0] : 2'b00},
              gv_b & gw_b, busy_b, to_b);
  endfunction

  task automatic push(input string tag, input bit sel, input logic [13:0] exp);
    item_t it;
    it.tag = tag;
    it.sel = sel;
    it.exp = exp;
    sb.push_back(it);
  endtask

  task automatic tick();
    item_t it;
    logic [13:0] obs;
    @(posedge clk);
    #1;
    while (sb.size() > 0) begin
      it  = sb.pop_front();
      obs = it.sel ? obs_b() : obs_a();
      n_cmp++;
      assert (obs === it.exp)
      else begin
        n_err++;
        $error("FAIL %s: observed %b expected %b", it.tag, obs, it.exp);
      end
    end
  endtask

  localparam logic [13:0] ZERO = 14'd0;

  initial begin
    reset = 1'b1;
    req_a = '0; rw_a = '0; rel_a = '0;
    req_b = '0; rw_b = '0; rel_b = '0;

    // Reset state
    tick();
    push("rst_a", 1'b0, ZERO);
    push("rst_b", 1'b1, ZERO);
    tick();
    reset = 1'b0;

    // Round robin on one channel, req=1010 held
    req_a = 4'b1010;
    push("t1_grant1", 1'b0, mk(2'b01, 4'd1, 2'b00, 4'b0010, 2'b00));
    tick();
    push("t1_hold", 1'b0, mk(2'b01, 4'd1, 2'b00, 4'b0010, 2'b00));
    tick();
    rel_a = 1'b1;
    push("t1_rel", 1'b0, ZERO);
    tick();
    rel_a = 1'b0;
    push("t1_grant3", 1'b0, mk(2'b01, 4'd3, 2'b00, 4'b1000, 2'b00));
    tick();
    rel_a = 1'b1;
    push("t1_rel2", 1'b0, ZERO);
    tick();
    rel_a = 1'b0;
    push("t1_wrap", 1'b0, mk(2'b01, 4'd1, 2'b00, 4'b0010, 2'b00));
    tick();
    rel_a = 1'b1;
    req_a = 4'b0000;
    push("t1_done", 1'b0, ZERO);
    tick();
    rel_a = 1'b0;

    // Write latching, then request and write dropped during the grant
    req_a = 4'b0100;
    rw_a  = 4'b0100;
    push("t3_grant", 1'b0, mk(2'b01, 4'd2, 2'b01, 4'b0100, 2'b00));
    tick();
    req_a = 4'b0000;
    rw_a  = 4'b0000;
    push("t3_frozen", 1'b0, mk(2'b01, 4'd2, 2'b01, 4'b0100, 2'b00));
    tick();
    push("t3_frozen2", 1'b0, mk(2'b01, 4'd2, 2'b01, 4'b0100, 2'b00));
    tick();
    rel_a = 1'b1;
    push("t3_rel", 1'b0, ZERO);
    tick();
    rel_a = 1'b0;

    // Watchdog expiry after eight grant cycles
    req_a = 4'b0001;
    push("t4_grant", 1'b0, mk(2'b01, 4'd0, 2'b00, 4'b0001, 2'b00));
    tick();
    req_a = 4'b0000;
    for (int i = 1; i < 8; i++) begin
      push($sformatf("t4_hold%0d", i), 1'b0, mk(2'b01, 4'd0, 2'b00, 4'b0001, 2'b00));
      tick();
    end
    push("t4_timeout", 1'b0, mk(2'b00, 4'd0, 2'b00, 4'b0000, 2'b01));
    tick();
    push("t4_pulse_end", 1'b0, ZERO);
    tick();

    // Same again, release coinciding with expiry suppresses the pulse
    req_a = 4'b0001;
    push("t4b_grant", 1'b0, mk(2'b01, 4'd0, 2'b00, 4'b0001, 2'b00));
    tick();
    req_a = 4'b0000;
    for (int i = 1; i < 8; i++) begin
      push($sformatf("t4b_hold%0d", i), 1'b0, mk(2'b01, 4'd0, 2'b00, 4'b0001, 2'b00));
      tick();
    end
    rel_a = 1'b1;
    push("t4b_rel_wins", 1'b0, ZERO);
    tick();
    rel_a = 1'b0;
    push("t4b_quiet", 1'b0, ZERO);
    tick();

    // Spurious release on an idle channel, and release alongside a fresh grant
    rel_a = 1'b1;
    push("t6_idle_rel", 1'b0, ZERO);
    tick();
    req_a = 4'b0010;
    push("t6_grant_with_rel", 1'b0, mk(2'b01, 4'd1, 2'b00, 4'b0010, 2'b00));
    tick();
    rel_a = 1'b0;
    push("t6_kept", 1'b0, mk(2'b01, 4'd1, 2'b00, 4'b0010, 2'b00));
    tick();
    rel_a = 1'b1;
    req_a = 4'b0000;
    push("t6_rel", 1'b0, ZERO);
    tick();
    rel_a = 1'b0;

    // Two channels, all consumers requesting at reset exit
    reset = 1'b1;
    push("t2_rst", 1'b1, ZERO);
    tick();
    reset = 1'b0;
    req_b = 4'b1111;
    push("t2_dual", 1'b1, mk(2'b11, {2'd1, 2'd0}, 2'b00, 4'b0011, 2'b00));
    tick();
    rel_b = 2'b01;
    push("t2_rel0", 1'b1, mk(2'b10, {2'd1, 2'd0}, 2'b00, 4'b0010, 2'b00));
    tick();
    rel_b = 2'b00;
    push("t2_regrant2", 1'b1, mk(2'b11, {2'd1, 2'd2}, 2'b00, 4'b0110, 2'b00));
    tick();

    // Reset mid-grant, then a single request from consumer 3
    reset = 1'b1;
    push("t5_reset", 1'b1, ZERO);
    push("t5_reset_a", 1'b0, ZERO);
    tick();
    reset = 1'b0;
    req_b = 4'b1000;
    push("t5_after", 1'b1, mk(2'b01, {2'd0, 2'd3}, 2'b00, 4'b1000, 2'b00));
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
